// File: rtl/wb_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_arb_pkg
// Brief   : Shared types, constants and helpers for the writeback port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_arb_pkg;

  localparam int NREQ_MAX = 5;

  localparam logic [2:0] SEL_REQ0 = 3'b000;
  localparam logic [2:0] SEL_REQ1 = 3'b001;
  localparam logic [2:0] SEL_REQ2 = 3'b010;
  localparam logic [2:0] SEL_REQ3 = 3'b011;
  localparam logic [2:0] SEL_REQ4 = 3'b100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  function automatic logic [2:0] idx_to_sign(input logic [2:0] idx);
    case (idx)
      3'd0:    idx_to_sign = SEL_REQ0;
      3'd1:    idx_to_sign = SEL_REQ1;
      3'd2:    idx_to_sign = SEL_REQ2;
      3'd3:    idx_to_sign = SEL_REQ3;
      3'd4:    idx_to_sign = SEL_REQ4;
      default: idx_to_sign = SEL_REQ0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module  : rr_pick
// Brief   : Combinational find-first-set over NREQ requesters, starting at the
//           index after ptr and wrapping, with masked bits excluded.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NREQ = 5
) (
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] mask,
  input  logic [2:0]      ptr,
  output logic [2:0]      idx,
  output logic            any_valid
);

  logic [7:0] w_elig;

  assign w_elig = {{(8-NREQ){1'b0}}, valid & ~mask};

  always_comb begin
    logic [3:0] cand;
    cand      = '0;
    idx       = '0;
    any_valid = 1'b0;
    // Visit ptr+1 .. ptr+NREQ modulo NREQ; ptr itself is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!any_valid && w_elig[cand[2:0]]) begin
        idx       = cand[2:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : wb_port_arbiter
// Brief   : Round-robin arbiter sharing the register-file writeback port among
//           up to five producers. Define WB_ARB_FIXED_PRIO_EN for fixed
//           lowest-index-wins priority instead of round-robin.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NREQ = 5,
  parameter int RW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*RW-1:0] req_rd,
  output logic [NREQ-1:0]  req_ready,
  input  logic             wb_stall,
  output logic [2:0]       mux_sign,
  output logic             wb_we,
  output logic [RW-1:0]    wb_rd,
  output logic             busy
);

  state_t          r_state;
  logic [2:0]      r_sel;
  logic [2:0]      r_mux_sign;
  logic [RW-1:0]   r_wb_rd;
`ifndef WB_ARB_FIXED_PRIO_EN
  logic [2:0]      r_last_grant;
`endif

  logic [RW-1:0]   w_rd_arr [8];
  logic [2:0]      w_ptr;
  logic [NREQ-1:0] w_mask;
  logic [2:0]      w_pick;
  logic            w_any;
  logic            w_commit;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rd
      if (gi < NREQ) begin : g_used
        assign w_rd_arr[gi] = req_rd[gi*RW +: RW];
      end else begin : g_unused
        assign w_rd_arr[gi] = '0;
      end
    end
  endgenerate

`ifdef WB_ARB_FIXED_PRIO_EN
  // Starting after the top index makes the search begin at requester 0.
  assign w_ptr  = 3'(NREQ-1);
  assign w_mask = '0;
`else
  // While writing, the completing requester becomes last_grant and is masked.
  assign w_ptr  = (r_state == WRITE) ? r_sel : r_last_grant;
  assign w_mask = (r_state == WRITE) ? (NREQ'(1) << r_sel) : '0;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .valid     (req_valid),
    .mask      (w_mask),
    .ptr       (w_ptr),
    .idx       (w_pick),
    .any_valid (w_any)
  );

  assign w_commit  = (r_state == WRITE) && !wb_stall;
  assign busy      = (r_state == WRITE);
  assign wb_we     = w_commit && (r_wb_rd != '0);
  assign req_ready = w_commit ? (NREQ'(1) << r_sel) : '0;
  assign mux_sign  = r_mux_sign;
  assign wb_rd     = r_wb_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_mux_sign   <= SEL_REQ0;
      r_wb_rd      <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      r_last_grant <= 3'(NREQ-1);
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel      <= w_pick;
            r_mux_sign <= idx_to_sign(w_pick);
            r_wb_rd    <= w_rd_arr[w_pick];
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          if (!wb_stall) begin
`ifndef WB_ARB_FIXED_PRIO_EN
            r_last_grant <= r_sel;
`endif
            if (w_any) begin
              r_sel      <= w_pick;
              r_mux_sign <= idx_to_sign(w_pick);
              r_wb_rd    <= w_rd_arr[w_pick];
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_wb_port_arbiter
// Brief   : Scoreboard bench for wb_port_arbiter (NREQ=5, RW=5).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid;
  logic [24:0] req_rd;
  logic [4:0]  req_ready;
  logic        wb_stall;
  logic [2:0]  mux_sign;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        busy;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .NREQ (5),
    .RW   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .mux_sign  (mux_sign),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .busy      (busy)
  );

  typedef struct packed {
    logic [2:0] sign;
    logic       we;
    logic [4:0] rd;
    logic [4:0] ready;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   hold_valid = 1'b0;

  task automatic expect_wr(input logic [2:0] s, input logic we, input logic [4:0] rd,
                           input logic [4:0] rdy);
    exp_t e;
    e.sign = s; e.we = we; e.rd = rd; e.ready = rdy;
    q.push_back(e);
  endtask

  task automatic set_rd(input int i, input logic [4:0] v);
    req_rd[i*5 +: 5] = v;
  endtask

  // One clock: apply stall, then sample and score any presented write.
  task automatic tick(input logic stall);
    exp_t e;
    @(posedge clk); #1;
    wb_stall = stall;
    #1;
    if (req_ready !== 5'b0) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got ready=%b sign=%b we=%b rd=%0d, no write expected",
                 req_ready, mux_sign, wb_we, wb_rd);
      end else begin
        e = q.pop_front();
        if ({mux_sign, wb_we, wb_rd, req_ready} !== e || busy !== 1'b1) begin
          n_err++;
          $display("FAIL wr_data: got sign=%b we=%b rd=%0d ready=%b busy=%b, want sign=%b we=%b rd=%0d ready=%b busy=1",
                   mux_sign, wb_we, wb_rd, req_ready, busy, e.sign, e.we, e.rd, e.ready);
        end
      end
      if (!hold_valid) req_valid = req_valid & ~req_ready;
    end
  endtask

  task automatic check_idle(input string tag);
    n_vec++;
    if (busy !== 1'b0 || req_ready !== 5'b0 || wb_we !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got busy=%b ready=%b we=%b, want busy=0 ready=00000 we=0",
               tag, busy, req_ready, wb_we);
    end
  endtask

  task automatic check_drained(input string tag);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d writes still pending, want 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_rd     = '0;
    wb_stall   = 1'b0;
    hold_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    wb_stall  = 1'b0;
    #2 rst_n  = 1'b0;
    req_valid = 5'b11111;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({mux_sign, wb_we, wb_rd, req_ready, busy} !== 15'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got sign=%b we=%b rd=%0d ready=%b busy=%b, want all zero",
               mux_sign, wb_we, wb_rd, req_ready, busy);
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 5'b00001;
    set_rd(0, 5'd5);
    expect_wr(3'b000, 1'b1, 5'd5, 5'b00001);
    tick(1'b0);
    tick(1'b0);
    check_idle("single_idle");
    check_drained("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 5'b10101;
    set_rd(0, 5'd1);
    set_rd(2, 5'd3);
    set_rd(4, 5'd5);
    expect_wr(3'b000, 1'b1, 5'd1, 5'b00001);
    expect_wr(3'b010, 1'b1, 5'd3, 5'b00100);
    expect_wr(3'b100, 1'b1, 5'd5, 5'b10000);
    repeat (3) tick(1'b0);
    tick(1'b0);
    check_idle("rr_idle");
    check_drained("rr");
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 5'b01000;
    set_rd(3, 5'd7);
    expect_wr(3'b011, 1'b1, 5'd7, 5'b01000);
    for (int c = 0; c < 3; c++) begin
      tick(1'b1);
      n_vec++;
      if (mux_sign !== 3'b011 || wb_we !== 1'b0 || req_ready !== 5'b0 || busy !== 1'b1
          || wb_rd !== 5'd7) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got sign=%b we=%b ready=%b busy=%b rd=%0d, want 011 0 00000 1 7",
                 c, mux_sign, wb_we, req_ready, busy, wb_rd);
      end
    end
    tick(1'b0);
    tick(1'b0);
    check_idle("stall_idle");
    check_drained("stall");
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 5'b00010;
    set_rd(1, 5'd0);
    expect_wr(3'b001, 1'b0, 5'd0, 5'b00010);
    tick(1'b0);
    tick(1'b0);
    check_idle("x0_idle");
    check_drained("x0");
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req_valid = 5'b00100;
    set_rd(2, 5'd9);
    tick(1'b1);
    n_vec++;
    if (mux_sign !== 3'b010 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: got sign=%b busy=%b, want 010 1", mux_sign, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mux_sign, wb_we, wb_rd, req_ready, busy} !== 15'b0) begin
      n_err++;
      $display("FAIL midrst_async: got sign=%b we=%b rd=%0d ready=%b busy=%b, want all zero",
               mux_sign, wb_we, wb_rd, req_ready, busy);
    end
    req_valid = 5'b00110;
    set_rd(1, 5'd4);
    wb_stall = 1'b0;
    expect_wr(3'b001, 1'b1, 5'd4, 5'b00010);
    expect_wr(3'b010, 1'b1, 5'd9, 5'b00100);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) tick(1'b0);
    tick(1'b0);
    check_idle("midrst_idle");
    check_drained("midrst");
  endtask

`ifdef WB_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    hold_valid = 1'b1;
    req_valid  = 5'b00011;
    set_rd(0, 5'd2);
    set_rd(1, 5'd3);
    for (int c = 0; c < 6; c++) begin
      expect_wr(3'b000, 1'b1, 5'd2, 5'b00001);
      tick(1'b0);
    end
    req_valid  = '0;
    hold_valid = 1'b0;
    tick(1'b0);
    check_idle("fixed_idle");
    check_drained("fixed");
  endtask
`else
  task automatic test_single_hold();
    do_reset();
    hold_valid = 1'b1;
    req_valid  = 5'b00001;
    set_rd(0, 5'd6);
    expect_wr(3'b000, 1'b1, 5'd6, 5'b00001);
    tick(1'b0);
    tick(1'b0);
    check_idle("hold_gap");
    expect_wr(3'b000, 1'b1, 5'd6, 5'b00001);
    tick(1'b0);
    req_valid  = '0;
    hold_valid = 1'b0;
    tick(1'b0);
    check_idle("hold_idle");
    check_drained("hold");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_x0();
    test_reset_mid_write();
`ifdef WB_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_single_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
